// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the program-counter sequencer.
// Holds the FSM state encoding, the fault cause codes and a strobe-conflict helper.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        ISR   = 2'd1,
        FAULT = 2'd2
    } state_t;

    localparam logic [1:0] FC_NONE = 2'b00;
    localparam logic [1:0] FC_OVF  = 2'b01;
    localparam logic [1:0] FC_UNF  = 2'b10;
    localparam logic [1:0] FC_ILL  = 2'b11;

    // True when two or more control-transfer strobes are raised together.
    function automatic logic multi_strobe(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/ret_stack.sv
// Return-address LIFO shared by call/ret and interrupt entry/exit.
// Only the occupancy count is reset; the entries are plain storage.
module ret_stack #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8,
    localparam int SP_W  = $clog2(DEPTH + 1),
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] top,
    output logic [SP_W-1:0]  count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] top_idx;

    assign full    = (count == SP_W'(DEPTH));
    assign empty   = (count == '0);
    assign wr_idx  = IDX_W'(count);
    assign top_idx = IDX_W'(count - SP_W'(1));
    assign top     = empty ? '0 : mem[top_idx];

    // NOTE: the array carries no reset; a popped slot is always one written earlier.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_idx] <= din;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (push && !full) begin
            count <= count + SP_W'(1);
        end else if (pop && !empty) begin
            count <= count - SP_W'(1);
        end
    end

endmodule

// File: rtl/pc_seq.sv
// Program-counter sequencer: next-PC priority, return stack, one maskable
// interrupt and a terminal fault state for stack misuse.
module pc_seq
    import pc_seq_pkg::*;
#(
    parameter int PC_W      = 10,
    parameter int DEPTH     = 8,
    parameter int RESET_VEC = 0,
    parameter int IRQ_VEC   = 1,
    localparam int SP_W     = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic            s_inc,
    input  logic [PC_W-1:0] dest,
    input  logic            call,
    input  logic            ret,
    input  logic            reti,
    input  logic            irq,
    output logic [PC_W-1:0] pc,
    output logic            irq_ack,
    output logic            in_isr,
    output logic [SP_W-1:0] sp,
    output logic            fault,
    output logic [1:0]      fault_cause
);

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [1:0]      cause_q, cause_d;
    logic [PC_W-1:0] pc_inc, seq_pc, push_data, top;
    logic            push, pop, full, empty, ack;

    assign pc_inc = pc_q + PC_W'(1);
    assign seq_pc = s_inc ? pc_inc : dest;

    ret_stack #(
        .WIDTH (PC_W),
        .DEPTH (DEPTH)
    ) u_stack (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (push_data),
        .top   (top),
        .count (sp),
        .full  (full),
        .empty (empty)
    );

    // NOTE: every output starts from a hold default, so no branch can infer a latch.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        cause_d   = cause_q;
        push      = 1'b0;
        pop       = 1'b0;
        push_data = pc_inc;
        ack       = 1'b0;

        if (en && state_q != FAULT) begin
            if (multi_strobe(call, ret, reti) || (reti && state_q == RUN)) begin
                state_d = FAULT;
                cause_d = FC_ILL;
            end else if (reti || ret) begin
                if (empty) begin
                    state_d = FAULT;
                    cause_d = FC_UNF;
                end else begin
                    pop  = 1'b1;
                    pc_d = top;
                    if (reti) begin
                        state_d = RUN;
                    end
                end
            end else if (call) begin
                if (full) begin
                    state_d = FAULT;
                    cause_d = FC_OVF;
                end else begin
                    push = 1'b1;
                    pc_d = dest;
                end
            end else if (irq && state_q == RUN) begin
                // The return address is where the interrupted instruction would have gone.
                if (full) begin
                    state_d = FAULT;
                    cause_d = FC_OVF;
                end else begin
                    push      = 1'b1;
                    push_data = seq_pc;
                    pc_d      = PC_W'(IRQ_VEC);
                    state_d   = ISR;
                    ack       = 1'b1;
                end
            end else begin
                pc_d = seq_pc;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            pc_q    <= PC_W'(RESET_VEC);
            cause_q <= FC_NONE;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cause_q <= cause_d;
        end
    end

    assign pc          = pc_q;
    assign irq_ack     = ack & ~reset;
    assign in_isr      = (state_q == ISR);
    assign fault       = (state_q == FAULT);
    assign fault_cause = cause_q;

endmodule

// File: tb/tb_pc_seq.sv
// Directed bench for pc_seq: the driver queues the outputs expected in each
// cycle and a negedge monitor pops and compares them.
module tb_pc_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic       en, s_inc, call, ret, reti, irq;
    logic [9:0] dest;
    logic [9:0] pc;
    logic       irq_ack, in_isr, fault;
    logic [3:0] sp;
    logic [1:0] fault_cause;

    int errors = 0;
    int checks = 0;
    int rec_n  = 0;

    typedef struct {
        logic [9:0] pc;
        logic [3:0] sp;
        logic       isr;
        logic       fault;
        logic [1:0] cause;
        logic       ack;
    } exp_t;

    exp_t sb [$];

    pc_seq dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .s_inc       (s_inc),
        .dest        (dest),
        .call        (call),
        .ret         (ret),
        .reti        (reti),
        .irq         (irq),
        .pc          (pc),
        .irq_ack     (irq_ack),
        .in_isr      (in_isr),
        .sp          (sp),
        .fault       (fault),
        .fault_cause (fault_cause)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            check($sformatf("pc[%0d]", rec_n), 32'(pc), 32'(e.pc));
            check($sformatf("sp[%0d]", rec_n), 32'(sp), 32'(e.sp));
            check($sformatf("in_isr[%0d]", rec_n), 32'(in_isr), 32'(e.isr));
            check($sformatf("fault[%0d]", rec_n), 32'(fault), 32'(e.fault));
            check($sformatf("cause[%0d]", rec_n), 32'(fault_cause), 32'(e.cause));
            check($sformatf("irq_ack[%0d]", rec_n), 32'(irq_ack), 32'(e.ack));
            rec_n++;
        end
    end

    // Applies one cycle of inputs and queues the outputs expected during that cycle.
    task automatic cyc(input logic i_en, input logic i_inc, input logic [9:0] i_dest,
                       input logic i_call, input logic i_ret, input logic i_reti, input logic i_irq,
                       input logic [9:0] e_pc, input logic [3:0] e_sp, input logic e_isr,
                       input logic e_fault, input logic [1:0] e_cause, input logic e_ack);
        exp_t e;
        en = i_en; s_inc = i_inc; dest = i_dest;
        call = i_call; ret = i_ret; reti = i_reti; irq = i_irq;
        e.pc = e_pc; e.sp = e_sp; e.isr = e_isr;
        e.fault = e_fault; e.cause = e_cause; e.ack = e_ack;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_irq();
        en = 1'b1; s_inc = 1'b1; dest = '0;
        call = 1'b0; ret = 1'b0; reti = 1'b0; irq = 1'b1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_pc"}, 32'(pc), 32'd0);
        check({tag, "_sp"}, 32'(sp), 32'd0);
        check({tag, "_isr"}, 32'(in_isr), 32'd0);
        check({tag, "_fault"}, 32'(fault), 32'd0);
        check({tag, "_cause"}, 32'(fault_cause), 32'd0);
        check({tag, "_ack"}, 32'(irq_ack), 32'd0);
    endtask

    // Asserts reset between clock edges and checks the asynchronous clear.
    task automatic do_reset(input string tag);
        idle_irq();
        reset = 1'b1;
        #1;
        check_reset_state(tag);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        idle_irq();
        #2;
        check_reset_state("por");
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Sequential run, call/ret.
        for (int i = 0; i < 3; i++) cyc(1,1,0,  0,0,0,0,  10'(i),0,0,0,0,0);
        cyc(1,1,20, 1,0,0,0,  3,0,0,0,0,0);
        cyc(1,1,0,  0,1,0,0,  20,1,0,0,0,0);
        cyc(1,1,0,  0,0,0,0,  4,0,0,0,0,0);

        // Interrupt entry, masking, nested call in ISR, reti, retake.
        cyc(1,1,0,  0,0,0,1,  5,0,0,0,0,1);
        cyc(1,1,0,  0,0,0,1,  1,1,1,0,0,0);
        cyc(1,1,0,  0,0,0,1,  2,1,1,0,0,0);
        cyc(1,1,40, 1,0,0,1,  3,1,1,0,0,0);
        cyc(1,1,0,  0,1,0,1,  40,2,1,0,0,0);
        cyc(1,1,0,  0,0,1,1,  4,1,1,0,0,0);
        cyc(1,1,0,  0,0,0,1,  6,0,0,0,0,1);
        cyc(1,1,0,  0,0,1,0,  1,1,1,0,0,0);

        // Deferral behind a call, stall in ISR and in RUN.
        cyc(1,1,30, 1,0,0,1,  7,0,0,0,0,0);
        cyc(1,1,0,  0,0,0,1,  30,1,0,0,0,1);
        for (int i = 0; i < 3; i++) cyc(0,1,99, 1,0,0,1,  1,2,1,0,0,0);
        cyc(1,1,0,  0,0,1,0,  1,2,1,0,0,0);
        cyc(1,1,0,  0,1,0,0,  31,1,0,0,0,0);
        for (int i = 0; i < 3; i++) cyc(0,1,99, 1,0,0,1,  8,0,0,0,0,0);

        // Jump and wrap of both pc+1 and the pushed return address.
        cyc(1,0,9,    0,0,0,0,  8,0,0,0,0,0);
        cyc(1,0,1022, 0,0,0,0,  9,0,0,0,0,0);
        cyc(1,1,0,    0,0,0,0,  1022,0,0,0,0,0);
        cyc(1,1,50,   1,0,0,0,  1023,0,0,0,0,0);
        cyc(1,1,0,    0,1,0,0,  50,1,0,0,0,0);
        cyc(1,1,0,    0,0,0,0,  0,0,0,0,0,0);
        cyc(1,0,1023, 0,0,0,0,  1,0,0,0,0,0);
        cyc(1,1,0,    0,0,0,0,  1023,0,0,0,0,0);
        cyc(1,1,0,    0,0,0,0,  0,0,0,0,0,0);

        // Fill the stack, then overflow on the 9th call; fault ignores all inputs.
        for (int k = 0; k < 8; k++)
            cyc(1,1,10'(100+k), 1,0,0,0,  (k == 0) ? 10'd1 : 10'(99+k),4'(k),0,0,0,0);
        cyc(1,1,200, 1,0,0,0,  107,8,0,0,0,0);
        for (int i = 0; i < 3; i++) cyc(1,1,0, 0,1,0,1,  107,8,0,1,2'b01,0);
        do_reset("rst_ovf");

        // Underflow on ret.
        cyc(1,1,0, 0,1,0,0,  0,0,0,0,0,0);
        cyc(1,1,0, 0,0,0,0,  0,0,0,1,2'b10,0);
        do_reset("rst_unf");

        // call+ret together.
        cyc(1,1,0, 0,0,0,0,  0,0,0,0,0,0);
        cyc(1,1,5, 1,0,0,0,  1,0,0,0,0,0);
        cyc(1,1,0, 1,1,0,0,  5,1,0,0,0,0);
        cyc(1,1,0, 0,0,0,0,  5,1,0,1,2'b11,0);
        do_reset("rst_ill");

        // reti outside an ISR.
        cyc(1,1,0, 0,0,1,0,  0,0,0,0,0,0);
        cyc(1,1,0, 0,0,0,0,  0,0,0,1,2'b11,0);
        do_reset("rst_reti");

        // Interrupt with a full stack: overflow, no ack.
        for (int k = 0; k < 8; k++)
            cyc(1,1,10'(100+k), 1,0,0,0,  (k == 0) ? 10'd0 : 10'(99+k),4'(k),0,0,0,0);
        cyc(1,1,0, 0,0,0,1,  107,8,0,0,0,0);
        cyc(1,1,0, 0,0,0,1,  107,8,0,1,2'b01,0);
        do_reset("rst_irqovf");

        // reti with an empty stack inside the ISR.
        cyc(1,1,0, 0,0,0,1,  0,0,0,0,0,1);
        cyc(1,1,0, 0,1,0,0,  1,1,1,0,0,0);
        cyc(1,1,0, 0,0,1,0,  1,0,1,0,0,0);
        cyc(1,1,0, 0,0,0,0,  1,0,0,1,2'b10,0);
        do_reset("rst_retiunf");

        // Asynchronous reset mid-ISR with three entries on the stack.
        cyc(1,1,0,  0,0,0,1,  0,0,0,0,0,1);
        cyc(1,1,60, 1,0,0,0,  1,1,1,0,0,0);
        cyc(1,1,70, 1,0,0,0,  60,2,1,0,0,0);
        check("pre_async_sp", 32'(sp), 32'd3);
        check("pre_async_isr", 32'(in_isr), 32'd1);
        #2;
        do_reset("async");
        cyc(1,1,0, 0,0,0,0,  0,0,0,0,0,0);
        cyc(1,1,0, 0,0,0,0,  1,0,0,0,0,0);

        #10;
        check("sb_drain", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_seq.md
Name: pc_seq

Overview:
- Parametrised program-counter sequencer for the single-cycle CPU datapath. It replaces the bare PC register + incrementer + next-PC mux.
- Adds four things the plain PC path lacks: a hardware return-address stack for call/ret, one maskable interrupt with entry/exit, a stall enable, and a fault trap on stack misuse.
- Drives the program-memory address. It is controlled by decoded strobes from the control unit.

Parameters:
- PC_W, 10, program-counter / program-memory address width.
- DEPTH, 8, return-stack entries (>=2).
- RESET_VEC, 0, PC value after reset.
- IRQ_VEC, 1, PC loaded on interrupt entry.
- SP_W, $clog2(DEPTH+1), width of the occupancy count (derived, not overridden).

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- en  in  1  advance enable; 0 = stall, all state held.
- s_inc  in  1  1 = sequential (PC+1), 0 = jump to dest.
- dest  in  PC_W  jump/call target (instruction immediate field).
- call  in  1  push PC+1, PC <= dest.
- ret  in  1  pop into PC.
- reti  in  1  return from interrupt: pop into PC, leave ISR.
- irq  in  1  level interrupt request.
- pc  out  PC_W  current PC (program-memory address).
- irq_ack  out  1  one-cycle pulse in the cycle the interrupt is taken.
- in_isr  out  1  state == ISR.
- sp  out  SP_W  stack occupancy 0..DEPTH.
- fault  out  1  state == FAULT.
- fault_cause  out  2  00 none, 01 overflow, 10 underflow, 11 illegal strobe combination.

Behaviour:
- Reset (async, any time, including mid-ISR):
  - pc=RESET_VEC, sp=0, state RUN.
  - irq_ack=0, fault=0, fault_cause=00.
  - Stack contents are don't-care.
- States:
  - RUN: normal; irq enabled.
  - ISR: servicing interrupt; irq masked.
  - FAULT: terminal; exits only by reset.
- en=0: pc, sp, state and stack held; irq_ack=0; strobes ignored.
- FAULT: pc frozen at its value at the fault cycle. All inputs are ignored.
- Next-PC computation, with en=1 in RUN/ISR, first match wins:
  1. More than one of {call, ret, reti} high -> FAULT, cause 11.
  2. reti in RUN -> FAULT, cause 11.
  3. reti in ISR: if sp==0 -> FAULT, cause 10; else pc<=top, sp-1, state RUN.
  4. ret: if sp==0 -> FAULT, cause 10; else pc<=top, sp-1.
  5. call: if sp==DEPTH -> FAULT, cause 01; else push pc+1, sp+1, pc<=dest.
  6. Otherwise: pc <= s_inc ? pc+1 : dest.
- Interrupt entry:
  - Condition: state RUN, en=1, irq=1, and no call/ret/reti this cycle (a control-transfer strobe defers the irq by one instruction).
  - Pushes the next-PC value computed in step 6, then pc<=IRQ_VEC, sp+1, state ISR, irq_ack=1 for that cycle.
  - If sp==DEPTH on entry -> FAULT, cause 01; irq_ack stays 0.
- A FAULT transition never modifies sp or stack contents.
- Arithmetic:
  - pc+1 is modulo 2^PC_W; all-ones wraps to 0.
  - The pushed return address wraps identically.
- Latency:
  - pc updates one clock after the strobes.
  - Popped value appears on pc the cycle after ret/reti.
  - sp changes in the same edge as pc.
- Nesting:
  - call/ret inside the ISR use the same stack.
  - irq re-arms only after reti returns to RUN.
- irq held high through reti is taken at the first RUN cycle after return.

Decomposition:
- Package pc_seq_pkg:
  - state enum {RUN, ISR, FAULT};
  - fault_cause constants FC_NONE/FC_OVF/FC_UNF/FC_ILL.
- Sub-module ret_stack (LIFO):
  - Parameters: width PC_W, depth DEPTH.
  - Interface: push/pop/din, top, count, full, empty.
  - Array plus pointer; no reset on the array.
- pc_seq holds the FSM, PC register, next-PC priority logic and irq_ack.

Test Plan:
- Sequential run and wrap, PC_W=4: reset, s_inc=1 for 17 cycles -> pc 0,1,..,15,0; jump with s_inc=0, dest=9 -> pc=9 the next cycle.
- Call/ret: pc=3, call dest=20 -> pc=20, sp=1; ret -> pc=4, sp=0. Nested 8 calls reach sp=8; a 9th call -> fault=1, cause 01, pc frozen, sp=8.
- Underflow and illegal: ret with sp=0 -> fault cause 10. Separately, call+ret together -> cause 11. Both clear only after reset.
- Interrupt:
  - pc=5, s_inc=1, irq=1 -> irq_ack pulse, pc=IRQ_VEC, in_isr=1, sp=1.
  - Holding irq while in ISR -> no second ack.
  - reti -> pc=6, in_isr=0, then irq is retaken.
- Deferral and stall:
  - irq asserted in the same cycle as call dest=30 -> pc=30 first, ack next cycle.
  - en=0 for 3 cycles mid-sequence -> pc/sp unchanged, no ack.
- Async reset mid-ISR with sp=3 -> pc=RESET_VEC, sp=0, in_isr=0 immediately, without waiting for a clock edge.
